// File: rtl/pipe_front_regs_pkg.sv
// pipe_front_regs_pkg
// Shared core constants for the RV32I front-end pipeline registers:
// the NOP encoding, the reset PC default, the control-word width and the
// bit positions inside the decoded control byte. It also holds the packed
// layouts of the IF/ID and ID/EX registers and a PC increment helper.
package pipe_front_regs_pkg;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  // Decoded control byte: {RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUSrc, spare}
  localparam int CTRL_W            = 8;
  localparam int CTRL_REGWRITE     = 7;
  localparam int CTRL_RESULTSRC_HI = 6;
  localparam int CTRL_RESULTSRC_LO = 5;
  localparam int CTRL_MEMWRITE     = 4;
  localparam int CTRL_JUMP         = 3;
  localparam int CTRL_BRANCH       = 2;
  localparam int CTRL_ALUSRC       = 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [31:0]       pc;
    logic [31:0]       pc_plus4;
    logic              valid;
  } idex_t;

  // Sequential fetch address; wraps naturally at 32 bits.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/pipe_front_regs_if.sv
// pipe_front_regs_if
// Bundles the hazard controls, fetch/decode inputs and the registered
// pipeline outputs of pipe_front_regs.
//   master: the surrounding core (drives hazard controls and D-stage fields)
//   slave : pipe_front_regs (drives PCF, IF/ID, ID/EX and the counters)
interface pipe_front_regs_if #(
  parameter int CNT_W = 16
);
  import pipe_front_regs_pkg::*;

  logic              StallF;
  logic              StallD;
  logic              FlushD;
  logic              FlushE;
  logic              PCSrcE;
  logic [31:0]       PCTargetE;
  logic [31:0]       InstrF;
  logic [4:0]        Rs1D_in;
  logic [4:0]        Rs2D_in;
  logic [4:0]        RdD_in;
  logic [CTRL_W-1:0] CtrlD;

  logic [31:0]       PCF;
  logic [31:0]       InstrD;
  logic [31:0]       PCD;
  logic [31:0]       PCPlus4D;
  logic              ValidD;
  logic [4:0]        Rs1E;
  logic [4:0]        Rs2E;
  logic [4:0]        RdE;
  logic [CTRL_W-1:0] CtrlE;
  logic [31:0]       PCE;
  logic [31:0]       PCPlus4E;
  logic              ValidE;
  logic [CNT_W-1:0]  StallCnt;
  logic [CNT_W-1:0]  FlushCnt;

  modport master (
    output StallF, StallD, FlushD, FlushE, PCSrcE, PCTargetE, InstrF,
           Rs1D_in, Rs2D_in, RdD_in, CtrlD,
    input  PCF, InstrD, PCD, PCPlus4D, ValidD, Rs1E, Rs2E, RdE, CtrlE,
           PCE, PCPlus4E, ValidE, StallCnt, FlushCnt
  );

  modport slave (
    input  StallF, StallD, FlushD, FlushE, PCSrcE, PCTargetE, InstrF,
           Rs1D_in, Rs2D_in, RdD_in, CtrlD,
    output PCF, InstrD, PCD, PCPlus4D, ValidD, Rs1E, Rs2E, RdE, CtrlE,
           PCE, PCPlus4E, ValidE, StallCnt, FlushCnt
  );

endinterface

// File: rtl/pipe_reg_en_clr.sv
// pipe_reg_en_clr
// Parameterized pipeline register with synchronous reset, clear and enable.
// Priority: reset > clear > enable > hold.
//   clk, reset : clock and synchronous active-high reset
//   en, clr    : load enable and synchronous clear
//   d, q       : data in / registered data out
module pipe_reg_en_clr #(
  parameter int             W       = 32,
  parameter logic [W-1:0]   RST_VAL = {W{1'b0}},
  parameter logic [W-1:0]   CLR_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Register update: clear beats enable so a flush always wins over a load.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RST_VAL;
    end else if (clr) begin
      q <= CLR_VAL;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/pipe_front_regs.sv
// pipe_front_regs
// Front-end pipeline registers of the 5-stage RV32I core: PC, IF/ID and
// ID/EX, with the hazard unit's stall/flush controls applied as register
// enables and clears, plus saturating stall/flush event counters.
//   clk, reset : core clock, synchronous active-high reset
//   bus        : slave side of pipe_front_regs_if (controls, D-stage fields,
//                registered PCF / IF-ID / ID-EX outputs, counters)
// Every output is a register output; ResultSrcE is CtrlE[6:5].
module pipe_front_regs #(
  parameter logic [31:0] RESET_PC  = pipe_front_regs_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = pipe_front_regs_pkg::NOP_INSTR_DEFAULT,
  parameter int          CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  pipe_front_regs_if.slave   bus
);
  import pipe_front_regs_pkg::*;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0, valid: 1'b0};
  localparam idex_t IDEX_BUBBLE = '{ctrl: {CTRL_W{1'b0}}, rs1: 5'd0, rs2: 5'd0, rd: 5'd0,
                                    pc: 32'h0, pc_plus4: 32'h0, valid: 1'b0};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [31:0]      pc_q;
  logic [31:0]      pc_d;
  logic             pc_en;
  ifid_t            ifid_q;
  ifid_t            ifid_d;
  idex_t            idex_q;
  idex_t            idex_d;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             stall_evt;

  // Next-value selection for the PC, IF/ID and ID/EX registers.
  always_comb begin
    pc_d   = pc_q;
    pc_en  = 1'b0;
    ifid_d = ifid_q;
    idex_d = idex_q;

    // A redirect overrides StallF: the stalled instruction is being flushed.
    if (bus.PCSrcE) begin
      pc_d  = bus.PCTargetE;
      pc_en = 1'b1;
    end else begin
      pc_d  = pc_plus4(pc_q);
      pc_en = ~bus.StallF;
    end

    ifid_d = '{instr: bus.InstrF, pc: pc_q, pc_plus4: pc_plus4(pc_q), valid: 1'b1};

    // ID/EX has no enable: StallD always comes with FlushE, so a held
    // decode stage feeds a bubble rather than a duplicate.
    idex_d = '{ctrl: bus.CtrlD, rs1: bus.Rs1D_in, rs2: bus.Rs2D_in, rd: bus.RdD_in,
               pc: ifid_q.pc, pc_plus4: ifid_q.pc_plus4, valid: ifid_q.valid};

    stall_evt = bus.StallF & ~bus.PCSrcE;
  end

  pipe_reg_en_clr #(.W(32), .RST_VAL(RESET_PC), .CLR_VAL(RESET_PC)) u_pc_reg (
    .clk(clk), .reset(reset), .en(pc_en), .clr(1'b0), .d(pc_d), .q(pc_q)
  );

  pipe_reg_en_clr #(.W($bits(ifid_t)), .RST_VAL(IFID_BUBBLE), .CLR_VAL(IFID_BUBBLE)) u_ifid_reg (
    .clk(clk), .reset(reset), .en(~bus.StallD), .clr(bus.FlushD), .d(ifid_d), .q(ifid_q)
  );

  pipe_reg_en_clr #(.W($bits(idex_t)), .RST_VAL(IDEX_BUBBLE), .CLR_VAL(IDEX_BUBBLE)) u_idex_reg (
    .clk(clk), .reset(reset), .en(1'b1), .clr(bus.FlushE), .d(idex_d), .q(idex_q)
  );

  // Saturating hazard event counters for debug readout.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= {CNT_W{1'b0}};
      flush_cnt <= {CNT_W{1'b0}};
    end else begin
      if (stall_evt && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (bus.PCSrcE && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end else begin
        flush_cnt <= flush_cnt;
      end
    end
  end

  assign bus.PCF      = pc_q;
  assign bus.InstrD   = ifid_q.instr;
  assign bus.PCD      = ifid_q.pc;
  assign bus.PCPlus4D = ifid_q.pc_plus4;
  assign bus.ValidD   = ifid_q.valid;
  assign bus.CtrlE    = idex_q.ctrl;
  assign bus.Rs1E     = idex_q.rs1;
  assign bus.Rs2E     = idex_q.rs2;
  assign bus.RdE      = idex_q.rd;
  assign bus.PCE      = idex_q.pc;
  assign bus.PCPlus4E = idex_q.pc_plus4;
  assign bus.ValidE   = idex_q.valid;
  assign bus.StallCnt = stall_cnt;
  assign bus.FlushCnt = flush_cnt;

endmodule

// File: tb/tb_pipe_front_regs.sv
// tb_pipe_front_regs
// Self-checking bench for pipe_front_regs (CNT_W=4 so saturation is quick).
// Each cycle the bench drives inputs on the falling edge, advances a small
// reference model of the front end, pushes the expected register contents
// into a scoreboard queue and compares them with the DUT #1 after the rising
// edge. Directed checks against fixed values cover the scenario milestones.
module tb_pipe_front_regs;

  localparam int CW = 4;

  typedef struct {
    logic [31:0] pcf;
    logic [31:0] instrd;
    logic [31:0] pcd;
    logic [31:0] pcp4d;
    logic        vd;
    logic [4:0]  rs1e;
    logic [4:0]  rs2e;
    logic [4:0]  rde;
    logic [7:0]  ctrle;
    logic [31:0] pce;
    logic [31:0] pcp4e;
    logic        ve;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;
  exp_t m;
  exp_t sb_q[$];

  pipe_front_regs_if #(.CNT_W(CW)) bus ();

  pipe_front_regs #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hABC0_0000 ^ pc;
  endfunction

  function automatic exp_t reset_state();
    exp_t r;
    r.pcf = 32'h0; r.instrd = 32'h0000_0013; r.pcd = 32'h0; r.pcp4d = 32'h0; r.vd = 1'b0;
    r.rs1e = 5'd0; r.rs2e = 5'd0; r.rde = 5'd0; r.ctrle = 8'h0;
    r.pce = 32'h0; r.pcp4e = 32'h0; r.ve = 1'b0; r.sc = '0; r.fc = '0;
    return r;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic compare_sb();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_val("PCF",      bus.PCF,            e.pcf);
      check_val("InstrD",   bus.InstrD,         e.instrd);
      check_val("PCD",      bus.PCD,            e.pcd);
      check_val("PCPlus4D", bus.PCPlus4D,       e.pcp4d);
      check_val("ValidD",   32'(bus.ValidD),    32'(e.vd));
      check_val("Rs1E",     32'(bus.Rs1E),      32'(e.rs1e));
      check_val("Rs2E",     32'(bus.Rs2E),      32'(e.rs2e));
      check_val("RdE",      32'(bus.RdE),       32'(e.rde));
      check_val("CtrlE",    32'(bus.CtrlE),     32'(e.ctrle));
      check_val("PCE",      bus.PCE,            e.pce);
      check_val("PCPlus4E", bus.PCPlus4E,       e.pcp4e);
      check_val("ValidE",   32'(bus.ValidE),    32'(e.ve));
      check_val("StallCnt", 32'(bus.StallCnt),  32'(e.sc));
      check_val("FlushCnt", 32'(bus.FlushCnt),  32'(e.fc));
    end
  endtask

  // One clock: drive inputs, advance the model, push expectation, compare.
  task automatic cyc(input logic rst, input logic sf, input logic sd, input logic fd,
                     input logic fe, input logic pcs, input logic [31:0] tgt);
    exp_t e;
    @(negedge clk);
    reset         = rst;
    bus.StallF    = sf;
    bus.StallD    = sd;
    bus.FlushD    = fd;
    bus.FlushE    = fe;
    bus.PCSrcE    = pcs;
    bus.PCTargetE = tgt;
    bus.InstrF    = instr_of(m.pcf);
    bus.Rs1D_in   = 5'($urandom);
    bus.Rs2D_in   = 5'($urandom);
    bus.RdD_in    = 5'($urandom);
    bus.CtrlD     = 8'($urandom);
    if (rst) begin
      e = reset_state();
    end else begin
      e = m;
      e.pcf = pcs ? tgt : (sf ? m.pcf : m.pcf + 32'd4);
      if (fd) begin
        e.instrd = 32'h0000_0013; e.pcd = 32'h0; e.pcp4d = 32'h0; e.vd = 1'b0;
      end else if (!sd) begin
        e.instrd = bus.InstrF; e.pcd = m.pcf; e.pcp4d = m.pcf + 32'd4; e.vd = 1'b1;
      end
      if (fe) begin
        e.rs1e = 5'd0; e.rs2e = 5'd0; e.rde = 5'd0; e.ctrle = 8'h0;
        e.pce = 32'h0; e.pcp4e = 32'h0; e.ve = 1'b0;
      end else begin
        e.rs1e = bus.Rs1D_in; e.rs2e = bus.Rs2D_in; e.rde = bus.RdD_in; e.ctrle = bus.CtrlD;
        e.pce = m.pcd; e.pcp4e = m.pcp4d; e.ve = m.vd;
      end
      if (sf && !pcs && (m.sc != {CW{1'b1}})) e.sc = m.sc + 1'b1;
      if (pcs && (m.fc != {CW{1'b1}})) e.fc = m.fc + 1'b1;
    end
    m = e;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare_sb();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_PCF"},    bus.PCF, 32'h0);
    check_val({tag, "_InstrD"}, bus.InstrD, 32'h0000_0013);
    check_val({tag, "_PCPlus4D"}, bus.PCPlus4D, 32'h0);
    check_val({tag, "_ValidD"}, 32'(bus.ValidD), 32'd0);
    check_val({tag, "_CtrlE"},  32'(bus.CtrlE), 32'd0);
    check_val({tag, "_ValidE"}, 32'(bus.ValidE), 32'd0);
    check_val({tag, "_StallCnt"}, 32'(bus.StallCnt), 32'd0);
    check_val({tag, "_FlushCnt"}, 32'(bus.FlushCnt), 32'd0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    m        = reset_state();
    reset = 1'b1;
    bus.StallF = 1'b0; bus.StallD = 1'b0; bus.FlushD = 1'b0; bus.FlushE = 1'b0;
    bus.PCSrcE = 1'b0; bus.PCTargetE = 32'h0; bus.InstrF = 32'h0;
    bus.Rs1D_in = 5'd0; bus.Rs2D_in = 5'd0; bus.RdD_in = 5'd0; bus.CtrlD = 8'h0;

    // Reset
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_reset_outputs("rst");

    // Free run: fetches 0,4,8,C
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_val("run1_InstrD", bus.InstrD, instr_of(32'h0));
    check_val("run1_ValidD", 32'(bus.ValidD), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_val("run2_PCE", bus.PCE, 32'h0);
    check_val("run2_ValidE", 32'(bus.ValidE), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_val("run4_PCF", bus.PCF, 32'h10);

    // Load-use stall at PCF=0x10
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    check_val("lu_PCF_hold", bus.PCF, 32'h10);
    check_val("lu_InstrD_hold", bus.InstrD, instr_of(32'hC));
    check_val("lu_ValidE", 32'(bus.ValidE), 32'd0);
    check_val("lu_StallCnt", 32'(bus.StallCnt), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_val("lu_PCF_next", bus.PCF, 32'h14);
    check_val("lu_InstrD_next", bus.InstrD, instr_of(32'h10));
    check_val("lu_ValidE_next", 32'(bus.ValidE), 32'd1);

    // Run to 0x20, then taken branch to 0x100
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_val("br_pre_PCF", bus.PCF, 32'h20);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h100);
    check_val("br_PCF", bus.PCF, 32'h100);
    check_val("br_InstrD", bus.InstrD, 32'h0000_0013);
    check_val("br_ValidD", 32'(bus.ValidD), 32'd0);
    check_val("br_CtrlE", 32'(bus.CtrlE), 32'd0);
    check_val("br_RdE", 32'(bus.RdE), 32'd0);
    check_val("br_ValidE", 32'(bus.ValidE), 32'd0);
    check_val("br_FlushCnt", 32'(bus.FlushCnt), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_val("br2_PCF", bus.PCF, 32'h104);
    check_val("br2_ValidE", 32'(bus.ValidE), 32'd0);

    // Simultaneous stall and redirect
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h200);
    check_val("sim_PCF", bus.PCF, 32'h200);
    check_val("sim_ValidD", 32'(bus.ValidD), 32'd0);
    check_val("sim_ValidE", 32'(bus.ValidE), 32'd0);
    check_val("sim_StallCnt", 32'(bus.StallCnt), 32'd1);
    check_val("sim_FlushCnt", 32'(bus.FlushCnt), 32'd2);

    // PC wrap
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
    check_val("wrap_PCF_top", bus.PCF, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_val("wrap_PCF", bus.PCF, 32'h0);
    check_val("wrap_PCD", bus.PCD, 32'hFFFF_FFFC);
    check_val("wrap_PCPlus4D", bus.PCPlus4D, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_val("wrap_PCPlus4E", bus.PCPlus4E, 32'h0);

    // Random hazard traffic, scoreboard only
    for (int i = 0; i < 120; i++) begin
      cyc(($urandom_range(31, 0) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), ($urandom_range(3, 0) == 0), {$urandom_range(255, 0), 2'b00} );
    end

    // Counter saturation, then reset mid-stall
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (20) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    check_val("sat_StallCnt", 32'(bus.StallCnt), 32'hF);
    check_val("sat_PCF", bus.PCF, 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    check_reset_outputs("midrst");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    check_val("post_rst_PCD", bus.PCD, 32'h0);
    check_val("post_rst_PCF", bus.PCF, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
